// File: rtl/multiport_regfile.sv
// Multi-issue register file: NLANES write ports, 2*NLANES read ports, cross-lane
// bypass, youngest-lane write priority, conflict flag and a sequential clear sweep.
//
// Ports:
//   clk, rst (sync, active-low)
//   we[NLANES], waddr/wdata per lane  -> write ports (dropped while busy)
//   raddr1/raddr2 per lane            -> combinational read data rdata1/rdata2
//   clr_req                           -> start a full-array clear sweep
//   busy                              -> clear sweep running
//   wr_conflict                       -> last cycle had a same-address multi-lane write
module multiport_regfile #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NLANES = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NLANES-1:0]          we,
    input  logic [NLANES*$clog2(DEPTH)-1:0] waddr,
    input  logic [NLANES*WIDTH-1:0]    wdata,
    input  logic [NLANES*$clog2(DEPTH)-1:0] raddr1,
    input  logic [NLANES*$clog2(DEPTH)-1:0] raddr2,
    input  logic                       clr_req,
    output logic [NLANES*WIDTH-1:0]    rdata1,
    output logic [NLANES*WIDTH-1:0]    rdata2,
    output logic                       busy,
    output logic                       wr_conflict
);

    localparam int AW = $clog2(DEPTH);
    localparam int NR = 2 * NLANES;

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state, state_d;
    logic [AW-1:0]    clr_cnt;
    logic             conflict_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wa [NLANES];
    logic [WIDTH-1:0] wd [NLANES];
    logic             wv [NLANES];
    logic [AW-1:0]    ra [NR];
    logic [WIDTH-1:0] rd [NR];

    // Unpack lane buses; a write is live only for a nonzero, in-range address.
    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            wa[l]      = waddr[l*AW +: AW];
            wd[l]      = wdata[l*WIDTH +: WIDTH];
            wv[l]      = we[l] && (wa[l] != '0) && (int'(wa[l]) < DEPTH);
            ra[l]      = raddr1[l*AW +: AW];
            ra[NLANES+l] = raddr2[l*AW +: AW];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_d;
            wr_conflict <= conflict_d;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            else if (clr_req)
                clr_cnt <= '0;
        end
    end

    // Next-state logic; clr_req during a sweep is deliberately ignored.
    always_comb begin
        state_d = state;
        unique case (state)
            CLEAR:   if (int'(clr_cnt) == DEPTH - 1) state_d = READY;
            READY:   if (clr_req) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == CLEAR);
    end

    always_comb begin
        conflict_d = 1'b0;
        if (state == READY) begin
            for (int i = 0; i < NLANES; i++)
                for (int j = i + 1; j < NLANES; j++)
                    if (we[i] && we[j] && wa[i] == wa[j] && wa[i] != '0)
                        conflict_d = 1'b1;
        end
    end

    // Array: the sweep owns it while clearing. Lanes are applied in
    // ascending order so the highest lane's write lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int l = 0; l < NLANES; l++)
                    if (wv[l]) mem[wa[l]] <= wd[l];
            end
        end
    end

    // Reads: array value, overridden by same-cycle writes when bypassing.
    always_comb begin
        for (int p = 0; p < NR; p++) begin
            rd[p] = '0;
            if (!busy && ra[p] != '0 && int'(ra[p]) < DEPTH) begin
                rd[p] = mem[ra[p]];
                if (BYPASS != 0) begin
                    for (int l = 0; l < NLANES; l++)
                        if (wv[l] && wa[l] == ra[p]) rd[p] = wd[l];
                end
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int l = 0; l < NLANES; l++) begin
            rdata1[l*WIDTH +: WIDTH] = rd[l];
            rdata2[l*WIDTH +: WIDTH] = rd[NLANES+l];
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: bypass and non-bypass instances
// share stimulus; each task checks one scenario inline.
module tb_multiport_regfile;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NL = 2;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NL-1:0]    we;
    logic [NL*AW-1:0] waddr, raddr1, raddr2;
    logic [NL*W-1:0]  wdata;
    logic             clr_req;
    logic [NL*W-1:0]  rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic             busy, wr_conflict, nb_busy, nb_wr_conflict;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multiport_regfile #(.WIDTH(W), .DEPTH(D), .NLANES(NL), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .clr_req(clr_req),
        .rdata1(rdata1), .rdata2(rdata2), .busy(busy), .wr_conflict(wr_conflict)
    );

    multiport_regfile #(.WIDTH(W), .DEPTH(D), .NLANES(NL), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .clr_req(clr_req),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .busy(nb_busy),
        .wr_conflict(nb_wr_conflict)
    );

    task automatic test_reset;
        int n;
        rst = 1'b0; we = '0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || wr_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state busy=%b conf=%b want 1/0", busy, wr_conflict);
        end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 32) begin
            n_bad++;
            $display("FAIL reset_busy_len got %0d want 32", n);
        end
        n_cmp++;
        if (nb_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nb_busy got %b want 0", nb_busy);
        end
        for (int i = 0; i < D; i++) begin
            raddr1[0 +: AW] = AW'(i);
            raddr2[AW +: AW] = AW'(i);
            #1;
            n_cmp++;
            if (rdata1[0 +: W] !== '0 || rdata2[W +: W] !== '0 ||
                nb_rdata1[0 +: W] !== '0) begin
                n_bad++;
                $display("FAIL reset_zero r%0d got %h/%h/%h want 0", i,
                         rdata1[0 +: W], rdata2[W +: W], nb_rdata1[0 +: W]);
            end
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        we = 2'b01;
        waddr[0 +: AW] = 5'd5;
        wdata[0 +: W] = 32'hAAAA_0001;
        raddr1[AW +: AW] = 5'd5;
        #1;
        n_cmp++;
        if (rdata1[W +: W] !== 32'hAAAA_0001) begin
            n_bad++;
            $display("FAIL bypass_same got %h want aaaa0001", rdata1[W +: W]);
        end
        n_cmp++;
        if (nb_rdata1[W +: W] !== 32'h0) begin
            n_bad++;
            $display("FAIL nobypass_same got %h want 0", nb_rdata1[W +: W]);
        end
        @(negedge clk);
        we = '0;
        raddr1[0 +: AW] = 5'd5;
        #1;
        n_cmp++;
        if (rdata1[0 +: W] !== 32'hAAAA_0001 ||
            nb_rdata1[0 +: W] !== 32'hAAAA_0001) begin
            n_bad++;
            $display("FAIL bypass_next got %h/%h want aaaa0001",
                     rdata1[0 +: W], nb_rdata1[0 +: W]);
        end
        n_cmp++;
        if (wr_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL bypass_conf got %b want 0", wr_conflict);
        end
    endtask

    task automatic test_conflict;
        @(negedge clk);
        we = 2'b11;
        waddr = {5'd7, 5'd7};
        wdata = {32'h22, 32'h11};
        raddr2[0 +: AW] = 5'd7;
        #1;
        n_cmp++;
        if (rdata2[0 +: W] !== 32'h22) begin
            n_bad++;
            $display("FAIL conf_bypass got %h want 22", rdata2[0 +: W]);
        end
        @(negedge clk);
        we = '0;
        raddr2[AW +: AW] = 5'd7;
        #1;
        n_cmp++;
        if (rdata2[W +: W] !== 32'h22 || nb_rdata2[W +: W] !== 32'h22) begin
            n_bad++;
            $display("FAIL conf_prio got %h/%h want 22",
                     rdata2[W +: W], nb_rdata2[W +: W]);
        end
        n_cmp++;
        if (wr_conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL conf_flag got %b want 1", wr_conflict);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL conf_clear got %b want 0", wr_conflict);
        end
    endtask

    task automatic test_reg0;
        @(negedge clk);
        we = 2'b11;
        waddr = '0;
        wdata = {32'hFFFF_FFFF, 32'h5A};
        raddr1[0 +: AW] = 5'd0;
        raddr2[AW +: AW] = 5'd0;
        #1;
        n_cmp++;
        if (rdata1[0 +: W] !== '0 || rdata2[W +: W] !== '0) begin
            n_bad++;
            $display("FAIL reg0_same got %h/%h want 0", rdata1[0 +: W], rdata2[W +: W]);
        end
        @(negedge clk);
        we = '0;
        #1;
        n_cmp++;
        if (rdata1[0 +: W] !== '0 || nb_rdata2[W +: W] !== '0) begin
            n_bad++;
            $display("FAIL reg0_next got %h/%h want 0", rdata1[0 +: W], nb_rdata2[W +: W]);
        end
        n_cmp++;
        if (wr_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL reg0_conf got %b want 0", wr_conflict);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        we = 2'b11;
        waddr = {5'd11, 5'd10};
        wdata = {32'h10B, 32'h10A};
        @(negedge clk);
        we = 2'b01;
        waddr[0 +: AW] = 5'd10;
        wdata[0 +: W] = 32'h20A;
        raddr1[AW +: AW] = 5'd10;
        #1;
        n_cmp++;
        if (rdata1[W +: W] !== 32'h20A || nb_rdata1[W +: W] !== 32'h10A) begin
            n_bad++;
            $display("FAIL b2b_same got %h/%h want 20a/10a",
                     rdata1[W +: W], nb_rdata1[W +: W]);
        end
        @(negedge clk);
        we = '0;
        raddr2[0 +: AW] = 5'd11;
        #1;
        n_cmp++;
        if (rdata1[W +: W] !== 32'h20A || rdata2[0 +: W] !== 32'h10B) begin
            n_bad++;
            $display("FAIL b2b_next got %h/%h want 20a/10b",
                     rdata1[W +: W], rdata2[0 +: W]);
        end
        n_cmp++;
        if (wr_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_conf got %b want 0", wr_conflict);
        end
    endtask

    task automatic test_clear;
        int n;
        @(negedge clk);
        we = '0;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            clr_req = (n == 10);
            we = 2'b11;
            waddr = {5'd2, 5'd2};
            wdata = {32'hB2, 32'hA2};
            raddr1[0 +: AW] = 5'd2;
            #1;
            n_cmp++;
            if (rdata1[0 +: W] !== '0 || wr_conflict !== 1'b0) begin
                n_bad++;
                $display("FAIL clr_sweep c%0d rd=%h conf=%b want 0/0",
                         n, rdata1[0 +: W], wr_conflict);
            end
            @(negedge clk);
        end
        we = '0;
        clr_req = 1'b0;
        n_cmp++;
        if (n != 32) begin
            n_bad++;
            $display("FAIL clr_busy_len got %0d want 32", n);
        end
        for (int i = 0; i < D; i++) begin
            raddr1[0 +: AW] = AW'(i);
            raddr2[AW +: AW] = AW'(i);
            #1;
            n_cmp++;
            if (rdata1[0 +: W] !== '0 || rdata2[W +: W] !== '0 ||
                nb_rdata2[W +: W] !== '0) begin
                n_bad++;
                $display("FAIL clr_zero r%0d got %h/%h/%h want 0", i,
                         rdata1[0 +: W], rdata2[W +: W], nb_rdata2[W +: W]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 32 || nb_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_restart got %0d nb=%b want 32/0", n, nb_busy);
        end
    endtask

    task automatic test_nobypass;
        @(negedge clk);
        we = 2'b01;
        waddr[0 +: AW] = 5'd3;
        wdata[0 +: W] = 32'h33;
        @(negedge clk);
        wdata[0 +: W] = 32'h3333_4444;
        raddr1[0 +: AW] = 5'd3;
        #1;
        n_cmp++;
        if (nb_rdata1[0 +: W] !== 32'h33 || rdata1[0 +: W] !== 32'h3333_4444) begin
            n_bad++;
            $display("FAIL nb_same got nb=%h byp=%h want 33/33334444",
                     nb_rdata1[0 +: W], rdata1[0 +: W]);
        end
        @(negedge clk);
        we = '0;
        #1;
        n_cmp++;
        if (nb_rdata1[0 +: W] !== 32'h3333_4444 || rdata1[0 +: W] !== 32'h3333_4444) begin
            n_bad++;
            $display("FAIL nb_next got nb=%h byp=%h want 33334444",
                     nb_rdata1[0 +: W], rdata1[0 +: W]);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_reg0();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_nobypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
